pwm_multi_ca: RTL and testbench
===============================

// Module: pwm_multi_ca
// PURPOSE
//  N-channel centre-aligned PWM generator for multi-leg power converters (e.g. 3-phase inverter).
//  One shared up/down carrier feeds a per-channel comparator and a per-channel dead-time inserter,
//  producing complementary high/low gate pairs.
//  Period, duties and dead time are shadowed: new values load atomically at the carrier valley.
//  Valley and peak trigger pulses start ADC/control interrupts elsewhere in the design.
// PARAMETERS
//  N_CH   3   number of complementary channels
//  CNT_W  16  width of carrier counter, period, duty and dead-time values
// PORTS
//  clk          in   1           single system clock, all logic on posedge
//  reset        in   1           asynchronous, active-high; clears all state
//  period       in   CNT_W       half-period P in clk cycles (shadowed)
//  duty         in   N_CH*CNT_W  channel k duty at [k*CNT_W +: CNT_W] (shadowed)
//  dead_time    in   CNT_W       turn-on delay DT in cycles, shared by all edges (shadowed)
//  pwm_enable   in   1           0 forces every gate output to 0
//  trig_enable  in   2           [0] gates trig_valley, [1] gates trig_peak
//  pwm_hi       out  N_CH        high-side gates
//  pwm_lo       out  N_CH        low-side gates
//  trig_valley  out  1           1-cycle pulse per carrier valley
//  trig_peak    out  1           1-cycle pulse per carrier peak
//  counter_dbg  out  CNT_W       current carrier value
// BEHAVIOUR
//  Reset (async): cnt=0, dir=up, shadows loaded as 0, all outputs 0.
//   First shadow load occurs at the first valley after reset release.
//  Carrier, P>=1: cnt runs 0,1..P-1,P-1,..1,0,0,1.. ; period = 2P cycles.
//   - up & cnt==P-1: hold, dir->down.
//   - down & cnt==0: hold, dir->up.
//   - P=1: cnt stays 0, dir toggles every cycle.
//  Valley event: down & cnt==0. Shadow regs (P, duty[], DT) load there and apply from the next cycle.
//  Peak event: up & cnt==P-1.
//  P==0: cnt held 0, dir=up, shadows load every cycle, all raw compares 0.
//  Raw compare (registered, +1 cycle): raw[k] = (cnt < duty_sh[k]).
//   - Gives exactly 2*D high cycles per period.
//   - D>=P: raw constantly 1. D==0: raw constantly 0.
//  Dead-time stage per channel (registered, +1 cycle):
//   - Turn-off edges follow raw with no extra delay.
//   - Turn-on edges are delayed by DT cycles: hi rises DT cycles after raw rises; lo rises DT cycles after raw falls.
//   - A raw pulse shorter than DT never turns that side on.
//   - hi & lo are never 1 together, including across shadow loads.
//   - DT=0: hi = raw, lo = ~raw, both 1 cycle after raw.
//  Total latency cnt->output edge = 2 cycles (+DT on turn-on).
//  pwm_enable=0: outputs 0 combinationally, dead-time counters cleared. On re-enable, each side waits a full DT before turning on.
//  Triggers: registered one cycle after the event, AND-ed with trig_enable bits. With P==0, no pulses.
//  Width: all compares unsigned CNT_W. DT saturating counter; no wrap.
//  Mid-run changes to inputs have no effect until the valley. Reset mid-period aborts immediately.
// STRUCTURE
//  Shared package pwm_pkg: CNT_W default, direction enum {DIR_UP, DIR_DOWN}, trig_enable bit indices.
//  Sub-module pwm_deadtime (one instance per channel, generate loop): in raw, dt, enable; out hi, lo.
//  Top holds shadow regs, carrier FSM, comparators and trigger regs.
// TESTING
//  1. P=4, duty0=2, DT=0, enable=1 -> cnt 0,1,2,3,3,2,1,0 repeating; hi0 high 4 of 8 cycles; lo0 = ~hi0.
//  2. P=10, duty0=5, DT=2 -> hi0 high 8 cycles, lo0 high 8 cycles, two 2-cycle both-low gaps per period; never both high.
//  3. Change duty0 4->7 mid-period -> old duty holds until valley; new duty applied from next period only.
//  4. duty=0 / duty=P / duty=P+5, DT=3 -> hi stuck 0 / 1 / 1, lo complementary; no glitch at the valley.
//  5. trig_enable=2'b11, P=6 -> trig_valley every 12 cycles, trig_peak 6 cycles offset; P=0 -> cnt 0, no triggers.
//  6. Async reset asserted mid-pulse -> all outputs 0 in the same cycle; after release, outputs stay 0 until the first valley load.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the centre-aligned PWM block.
// Carrier direction enum, default counter width, trigger enable bit indices.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  localparam int TRIG_VALLEY = 0;
  localparam int TRIG_PEAK   = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter: delays turn-on edges of the hi/lo pair by dt.
// Ports: clk, reset (async high), raw, dt, enable -> hi, lo (registered, gated).
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         raw,
  input  logic [W-1:0] dt,
  input  logic         enable,
  output logic         hi,
  output logic         lo
);

  logic         raw_d;
  logic         en_d;
  logic         hi_q;
  logic         lo_q;
  logic [W-1:0] age_q;
  logic [W-1:0] age_now;
  logic         aged;

  // Cycles raw has already held its current level
  // (while enabled), saturating instead of wrapping.
  always_comb begin
    age_now = '0;
    if (en_d && (raw == raw_d)) begin
      if (age_q == '1) begin
        age_now = age_q;
      end else begin
        age_now = age_q + W'(1);
      end
    end
  end

  assign aged = (age_now >= dt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_d <= 1'b0;
      en_d  <= 1'b0;
      age_q <= '0;
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
    end else if (!enable) begin
      raw_d <= raw;
      en_d  <= 1'b0;
      age_q <= '0;
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
    end else begin
      raw_d <= raw;
      en_d  <= 1'b1;
      age_q <= age_now;
      hi_q  <= raw & aged;
      lo_q  <= ~raw & aged;
    end
  end

  assign hi = hi_q & enable;
  assign lo = lo_q & enable;

endmodule

// File: rtl/pwm_multi_ca.sv
// N-channel centre-aligned PWM: shared up/down carrier, shadowed settings,
// per-channel compare + dead time, valley/peak trigger pulses, debug counter.
module pwm_multi_ca
  import pwm_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic [CNT_W-1:0]      dead_time,
  input  logic                  pwm_enable,
  input  logic [1:0]            trig_enable,
  output logic [N_CH-1:0]       pwm_hi,
  output logic [N_CH-1:0]       pwm_lo,
  output logic                  trig_valley,
  output logic                  trig_peak,
  output logic [CNT_W-1:0]      counter_dbg
);

  dir_e                  dir;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      p_sh;
  logic [CNT_W-1:0]      dt_sh;
  logic [N_CH*CNT_W-1:0] duty_sh;
  logic [N_CH-1:0]       raw;
  logic                  armed;

  logic                  p_zero;
  logic [CNT_W-1:0]      p_top;
  logic                  at_top;
  logic                  valley_ev;
  logic                  peak_ev;
  logic                  inc;
  logic                  dec;
  logic                  load;
  logic                  dt_en;

  assign p_zero    = (p_sh == '0);
  assign p_top     = p_sh - CNT_W'(1);
  assign at_top    = (cnt == p_top);
  assign valley_ev = !p_zero && (dir == DIR_DOWN)
                   && (cnt == '0);
  assign peak_ev   = !p_zero && (dir == DIR_UP)
                   && at_top;
  assign inc       = !p_zero && (dir == DIR_UP)
                   && !at_top;
  assign dec       = !p_zero && (dir == DIR_DOWN)
                   && (cnt != '0);
  // With no period loaded the shadows track the
  // inputs every cycle so the first valley is immediate.
  assign load      = p_zero || valley_ev;

  // Gates stay off until the first shadow load after reset.
  assign dt_en     = pwm_enable & armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir         <= DIR_UP;
      cnt         <= '0;
      p_sh        <= '0;
      dt_sh       <= '0;
      duty_sh     <= '0;
      raw         <= '0;
      armed       <= 1'b0;
      trig_valley <= 1'b0;
      trig_peak   <= 1'b0;
    end else begin
      if (load) begin
        p_sh    <= period;
        duty_sh <= duty;
        dt_sh   <= dead_time;
        armed   <= 1'b1;
      end
      unique case (1'b1)
        p_zero: begin
          cnt <= '0;
          dir <= DIR_UP;
        end
        peak_ev:   dir <= DIR_DOWN;
        valley_ev: dir <= DIR_UP;
        inc:       cnt <= cnt + CNT_W'(1);
        dec:       cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
      for (int k = 0; k < N_CH; k++) begin
        raw[k] <= !p_zero
          && (cnt < duty_sh[k*CNT_W +: CNT_W]);
      end
      trig_valley <= valley_ev
        & trig_enable[TRIG_VALLEY];
      trig_peak   <= peak_ev
        & trig_enable[TRIG_PEAK];
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_deadtime #(
      .W(CNT_W)
    ) u_dt (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[k]),
      .dt    (dt_sh),
      .enable(dt_en),
      .hi    (pwm_hi[k]),
      .lo    (pwm_lo[k])
    );
  end

  assign counter_dbg = cnt;

endmodule

// File: tb/tb_pwm_multi_ca.sv
// Self-checking bench for pwm_multi_ca: cycle scoreboard plus table of
// per-period gate counts and hand sequences for shadowing, triggers, reset.
module tb_pwm_multi_ca;

  localparam int N = 3;
  localparam int W = 16;

  logic           clk;
  logic           reset;
  logic [W-1:0]   period;
  logic [N*W-1:0] duty;
  logic [W-1:0]   dead_time;
  logic           pwm_enable;
  logic [1:0]     trig_enable;
  logic [N-1:0]   pwm_hi;
  logic [N-1:0]   pwm_lo;
  logic           trig_valley;
  logic           trig_peak;
  logic [W-1:0]   counter_dbg;

  pwm_multi_ca #(
    .N_CH (N),
    .CNT_W(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .period     (period),
    .duty       (duty),
    .dead_time  (dead_time),
    .pwm_enable (pwm_enable),
    .trig_enable(trig_enable),
    .pwm_hi     (pwm_hi),
    .pwm_lo     (pwm_lo),
    .trig_valley(trig_valley),
    .trig_peak  (trig_peak),
    .counter_dbg(counter_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic tv;
    logic tp;
  } exp_t;

  typedef struct {
    int p, d0, d1, d2, dt, hi, lo;
  } vec_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // reference model state: phase index within the 2P period
  int           m_p, m_dt, m_ph;
  int           m_d[N];
  bit           m_armed;
  logic [N-1:0] m_raw;
  logic [31:0]  rh[N];
  logic [31:0]  eh;

  function automatic int carrier(int p, int ph);
    if (p == 0) return 0;
    return (ph < p) ? ph : 2 * p - 1 - ph;
  endfunction

  task automatic model_step();
    exp_t e;
    int c_old;
    logic [N-1:0] hq;
    logic [N-1:0] lq;
    logic en_now;
    if (reset) begin
      m_p = 0; m_dt = 0; m_ph = 0; m_armed = 0;
      m_raw = '0; eh = '0;
      for (int k = 0; k < N; k++) begin
        m_d[k] = 0; rh[k] = '0;
      end
      e.cnt = 0; e.hi = '0; e.lo = '0;
      e.tv = 0; e.tp = 0;
      sbq.push_back(e);
      return;
    end
    c_old = carrier(m_p, m_ph);
    eh = {eh[30:0], pwm_enable & m_armed};
    for (int k = 0; k < N; k++) begin
      rh[k] = {rh[k][30:0], m_raw[k]};
      hq[k] = 1'b1;
      lq[k] = 1'b1;
      for (int j = 0; j <= m_dt; j++) begin
        if (!eh[j] || !rh[k][j]) hq[k] = 1'b0;
        if (!eh[j] || rh[k][j]) lq[k] = 1'b0;
      end
    end
    e.tv = (m_p != 0) && (m_ph == 2 * m_p - 1)
         && trig_enable[0];
    e.tp = (m_p != 0) && (m_ph == m_p - 1)
         && trig_enable[1];
    for (int k = 0; k < N; k++)
      m_raw[k] = (m_p != 0) && (c_old < m_d[k]);
    if (m_p == 0 || m_ph == 2 * m_p - 1) begin
      m_p = int'(period);
      m_dt = int'(dead_time);
      for (int k = 0; k < N; k++)
        m_d[k] = int'(duty[k*W +: W]);
      m_ph = 0;
      m_armed = 1;
    end else begin
      m_ph++;
    end
    e.cnt = carrier(m_p, m_ph);
    en_now = pwm_enable & m_armed;
    e.hi = hq & {N{en_now}};
    e.lo = lq & {N{en_now}};
    sbq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (int'(counter_dbg) != e.cnt || pwm_hi !== e.hi
          || pwm_lo !== e.lo || trig_valley !== e.tv
          || trig_peak !== e.tp) begin
        errors++;
        $display("FAIL sb t=%0t cnt %0d/%0d hi %b/%b lo %b/%b tv %b/%b tp %b/%b",
          $time, counter_dbg, e.cnt, pwm_hi, e.hi,
          pwm_lo, e.lo, trig_valley, e.tv, trig_peak, e.tp);
      end
      checks++;
      if ((pwm_hi & pwm_lo) != '0) begin
        errors++;
        $display("FAIL overlap t=%0t hi %b lo %b want no common bit",
          $time, pwm_hi, pwm_lo);
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_tv();
    int n = 0;
    while (trig_valley !== 1'b1 && n < 100) begin
      nxt();
      n++;
    end
    chk("wait_tv", int'(trig_valley), 1);
  endtask

  task automatic set_cfg(int p, int d0, int d1, int d2, int dt);
    period = W'(p);
    duty = {W'(d2), W'(d1), W'(d0)};
    dead_time = W'(dt);
  endtask

  vec_t tbl[7];

  initial begin
    int hc, lc, hc2, nv, np, bad, n;
    tbl[0] = '{4, 2, 1, 3, 0, 4, 4};
    tbl[1] = '{10, 5, 3, 8, 2, 8, 8};
    tbl[2] = '{10, 0, 4, 9, 3, 0, 20};
    tbl[3] = '{10, 10, 2, 6, 3, 20, 0};
    tbl[4] = '{10, 15, 7, 1, 3, 20, 0};
    tbl[5] = '{6, 1, 5, 3, 3, 0, 7};
    tbl[6] = '{1, 1, 0, 2, 0, 2, 0};

    reset = 1'b1;
    set_cfg(0, 0, 0, 0, 0);
    pwm_enable = 1'b0;
    trig_enable = 2'b00;
    repeat (3) nxt();
    chk("rst_cnt", int'(counter_dbg), 0);
    chk("rst_gates", int'({pwm_hi, pwm_lo}), 0);
    chk("rst_trig", int'({trig_valley, trig_peak}), 0);
    reset = 1'b0;
    pwm_enable = 1'b1;
    trig_enable = 2'b11;

    for (int i = 0; i < 7; i++) begin
      set_cfg(tbl[i].p, tbl[i].d0, tbl[i].d1,
              tbl[i].d2, tbl[i].dt);
      repeat (60) nxt();
      hc = 0;
      lc = 0;
      for (int c = 0; c < 2 * tbl[i].p; c++) begin
        hc += int'(pwm_hi[0]);
        lc += int'(pwm_lo[0]);
        nxt();
      end
      chk($sformatf("tbl%0d_hi", i), hc, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), lc, tbl[i].lo);
    end

    // duty change mid-period waits for the valley
    set_cfg(10, 4, 2, 2, 0);
    repeat (60) nxt();
    wait_tv();
    hc = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) nxt();
      hc += int'(pwm_hi[0]);
      if (i == 5) duty[W-1:0] = W'(7);
    end
    hc2 = 0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      hc2 += int'(pwm_hi[0]);
    end
    chk("shadow_old_duty", hc, 8);
    chk("shadow_new_duty", hc2, 14);

    // trigger spacing
    set_cfg(6, 3, 3, 3, 1);
    trig_enable = 2'b11;
    repeat (40) nxt();
    wait_tv();
    nv = 0;
    np = 0;
    bad = 0;
    for (int i = 1; i <= 36; i++) begin
      nxt();
      if (trig_valley) begin
        nv++;
        if (i % 12 != 0) bad++;
      end
      if (trig_peak) begin
        np++;
        if (i % 12 != 6) bad++;
      end
    end
    chk("trig_valley_n", nv, 3);
    chk("trig_peak_n", np, 3);
    chk("trig_phase", bad, 0);

    trig_enable = 2'b01;
    nv = 0;
    np = 0;
    for (int i = 0; i < 24; i++) begin
      nxt();
      nv += int'(trig_valley);
      np += int'(trig_peak);
    end
    chk("trig_gate_v", nv, 2);
    chk("trig_gate_p", np, 0);

    trig_enable = 2'b11;
    period = '0;
    repeat (30) nxt();
    n = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      n += int'(trig_valley) + int'(trig_peak);
      if (counter_dbg != '0) bad++;
    end
    chk("p0_trig", n, 0);
    chk("p0_cnt", bad, 0);

    // enable gating and re-enable dead time
    set_cfg(10, 5, 3, 8, 2);
    repeat (60) nxt();
    pwm_enable = 1'b0;
    #1;
    chk("dis_gates", int'({pwm_hi, pwm_lo}), 0);
    repeat (5) nxt();
    pwm_enable = 1'b1;
    repeat (30) nxt();

    // async reset mid pulse
    set_cfg(10, 5, 3, 8, 0);
    repeat (60) nxt();
    n = 0;
    while (pwm_hi[0] !== 1'b1 && n < 40) begin
      nxt();
      n++;
    end
    chk("hi_before_rst", int'(pwm_hi[0]), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_gates", int'({pwm_hi, pwm_lo}), 0);
    chk("arst_cnt", int'(counter_dbg), 0);
    repeat (2) nxt();
    reset = 1'b0;
    #1;
    chk("rel_gates", int'({pwm_hi, pwm_lo}), 0);
    nxt();
    chk("rel_gates_1", int'({pwm_hi, pwm_lo}), 0);
    repeat (40) nxt();

    repeat (3) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
